// File: rtl/data_mem_responder_if.sv
// CPU data-port bus between a CPU (master) and the data memory responder (slave).
// Handshake: DREQ is a one-cycle strobe with no ready; the responder accepts every
// access on the edge it is presented, and read data appears on DRDATA one edge later.
interface data_mem_responder_if;
  logic        DREQ;
  logic        DRW;
  logic [29:0] DADDR;
  logic [31:0] DWDATA;
  logic [31:0] DRDATA;
  logic        ERR;
  logic [1:0]  WB_CNT;

  modport master (output DREQ, DRW, DADDR, DWDATA, input DRDATA, ERR, WB_CNT);
  modport slave  (input DREQ, DRW, DADDR, DWDATA, output DRDATA, ERR, WB_CNT);
endinterface

// File: rtl/data_mem_responder.sv
// Single-ported data memory with a 2-entry posted write buffer. Reads forward from the
// buffer and are serviced before drains; writes never stall.
module data_mem_responder #(
  parameter int AW    = 10,
  parameter int ENTRY = 1024
) (
  input logic                 CLK,
  input logic                 RSTN,
  data_mem_responder_if.slave bus
);

  logic [31:0]   mem [ENTRY];

  logic [AW-1:0] wb_addr [2];
  logic [31:0]   wb_data [2];
  logic [1:0]    wb_cnt;

  logic [AW-1:0] n_addr [2];
  logic [31:0]   n_data [2];
  logic [1:0]    n_cnt;

  logic [31:0]   drdata_q;
  logic          err_q;

  logic [AW-1:0] req_addr;
  logic          oor;
  logic          rd;
  logic          wr;
  logic          drain;
  logic          hit0;
  logic          hit1;
  logic [31:0]   rd_data;
  logic [31:0]   mem_wdata;

  assign req_addr = bus.DADDR[AW-1:0];
  assign oor      = bus.DREQ && (bus.DADDR[29:AW] != '0);
  assign rd       = bus.DREQ && !bus.DRW && !oor;
  assign wr       = bus.DREQ && bus.DRW && !oor;
  // The array port belongs to the CPU on any read cycle, including a rejected one.
  assign drain    = !(bus.DREQ && !bus.DRW) && (wb_cnt != 2'd0);

  // Entry addresses are unique because matching writes merge, so at most one hit.
  assign hit0     = (wb_cnt != 2'd0) && (wb_addr[0] == req_addr);
  assign hit1     = (wb_cnt == 2'd2) && (wb_addr[1] == req_addr);

  always_comb begin
    rd_data = mem[req_addr];
    if (hit0) rd_data = wb_data[0];
    if (hit1) rd_data = wb_data[1];
  end

  // A write merging into the entry being drained goes straight to the array.
  assign mem_wdata = (wr && hit0) ? bus.DWDATA : wb_data[0];

  always_comb begin
    n_addr = wb_addr;
    n_data = wb_data;
    n_cnt  = wb_cnt;
    if (wr && hit1) n_data[1] = bus.DWDATA;
    if (wr && hit0 && !drain) n_data[0] = bus.DWDATA;
    if (drain) begin
      n_addr[0] = wb_addr[1];
      n_data[0] = n_data[1];
      n_cnt     = wb_cnt - 2'd1;
    end
    if (wr && !hit0 && !hit1) begin
      if (n_cnt == 2'd0) begin
        n_addr[0] = req_addr;
        n_data[0] = bus.DWDATA;
      end else begin
        n_addr[1] = req_addr;
        n_data[1] = bus.DWDATA;
      end
      n_cnt = n_cnt + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wb_cnt   <= 2'd0;
      drdata_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      wb_cnt <= n_cnt;
      err_q  <= oor;
      if (bus.DREQ && !bus.DRW) drdata_q <= oor ? 32'd0 : rd_data;
    end
  end

  // Entry payloads carry no reset; occupancy alone decides which entries are live.
  always_ff @(posedge CLK) begin
    wb_addr <= n_addr;
    wb_data <= n_data;
  end

  always_ff @(posedge CLK) begin
    if (drain) mem[wb_addr[0]] <= mem_wdata;
  end

  assign bus.DRDATA = drdata_q;
  assign bus.ERR    = err_q;
  assign bus.WB_CNT = wb_cnt;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder, checked against a
// pending-write-queue reference model.
module tb_data_mem_responder;

  logic CLK;
  logic RSTN;

  data_mem_responder_if bus ();

  data_mem_responder #(.AW(10), .ENTRY(1024)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] ref_mem [1024];
  bit          ref_known [1024];
  logic [31:0] m_dr;
  bit          m_dr_known;
  logic        m_err;
  logic [31:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Observable behaviour: reads see the latest write to an address unless a reset
  // discarded it while still pending; pending writes retire one per free port cycle.
  task automatic model_step(input logic req, input logic rw, input logic [29:0] a, input logic [31:0] d);
    bit oor;
    bit merged;
    int pre;
    oor   = req && (a[29:10] != 20'd0);
    m_err = oor;
    if (req && !rw) begin
      if (oor) begin
        m_dr = 32'd0;
        m_dr_known = 1;
      end else begin
        m_dr_known = ref_known[a[9:0]];
        m_dr = ref_mem[a[9:0]];
        for (int i = 0; i < pend_q.size(); i++)
          if (pend_q[i].a == a[9:0]) begin
            m_dr = pend_q[i].d;
            m_dr_known = 1;
          end
      end
    end else begin
      pre = pend_q.size();
      if (req && rw && !oor) begin
        merged = 0;
        for (int i = 0; i < pend_q.size(); i++)
          if (pend_q[i].a == a[9:0]) begin
            pend_q[i].d = d;
            merged = 1;
          end
        if (!merged) pend_q.push_back('{a: a[9:0], d: d});
      end
      if (pre > 0) begin
        ref_mem[pend_q[0].a]   = pend_q[0].d;
        ref_known[pend_q[0].a] = 1;
        void'(pend_q.pop_front());
      end
    end
    if (m_dr_known) exp_q.push_back(m_dr);
  endtask

  task automatic bus_cycle(input logic req, input logic rw, input logic [29:0] a, input logic [31:0] d);
    logic [31:0] e;
    bus.DREQ   = req;
    bus.DRW    = rw;
    bus.DADDR  = a;
    bus.DWDATA = d;
    @(posedge CLK);
    model_step(req, rw, a, d);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("drdata", bus.DRDATA, e);
    end
    check("err", {31'd0, bus.ERR}, {31'd0, m_err});
    check("wb_cnt", {30'd0, bus.WB_CNT}, 32'(pend_q.size()));
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    bus_cycle(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [29:0] a);
    bus_cycle(1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic idle();
    bus_cycle(1'b0, 1'b0, 30'd0, 32'd0);
  endtask

  // Asserted between edges so the outputs must clear without a clock.
  task automatic do_reset();
    bus.DREQ = 1'b0;
    RSTN = 1'b0;
    #1;
    check("rst_drdata", bus.DRDATA, 32'd0);
    check("rst_err", {31'd0, bus.ERR}, 32'd0);
    check("rst_wb_cnt", {30'd0, bus.WB_CNT}, 32'd0);
    pend_q.delete();
    m_dr = 32'd0;
    m_dr_known = 1;
    m_err = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  logic [31:0] v4;
  logic [29:0] ra;
  int          op;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 32'd0;
      ref_known[i] = 0;
    end
    m_dr = 32'd0;
    m_dr_known = 1;
    m_err = 1'b0;
    bus.DREQ = 1'b0;
    bus.DRW = 1'b0;
    bus.DADDR = 30'd0;
    bus.DWDATA = 32'd0;
    RSTN = 1'b1;
    #3;
    do_reset();

    for (int i = 0; i < 16; i++) wr(30'(i), $urandom);
    idle();
    idle();

    // Forwarding of a freshly posted write.
    wr(30'd5, 32'h12345678);
    check("r29_wb_cnt_wr", {30'd0, bus.WB_CNT}, 32'd1);
    rd(30'd5);
    check("r29_rd", bus.DRDATA, 32'h12345678);
    check("r29_wb_cnt_rd", {30'd0, bus.WB_CNT}, 32'd1);
    idle();

    wr(30'd1, 32'h11);
    check("r30_cnt_a", {30'd0, bus.WB_CNT}, 32'd1);
    wr(30'd2, 32'h22);
    check("r30_cnt_b", {30'd0, bus.WB_CNT}, 32'd1);
    wr(30'd3, 32'h33);
    check("r30_cnt_c", {30'd0, bus.WB_CNT}, 32'd1);
    rd(30'd1);
    check("r30_rd1", bus.DRDATA, 32'h11);
    rd(30'd2);
    check("r30_rd2", bus.DRDATA, 32'h22);
    rd(30'd3);
    check("r30_rd3", bus.DRDATA, 32'h33);
    idle();

    // Merge into the entry that drains in the same cycle.
    wr(30'd7, 32'hAA);
    wr(30'd7, 32'hBB);
    for (int i = 0; i < 4; i++) begin
      rd(30'd7);
      check("r31_rd", bus.DRDATA, 32'hBB);
    end
    idle();
    check("r31_cnt", {30'd0, bus.WB_CNT}, 32'd0);
    rd(30'd7);
    check("r31_array", bus.DRDATA, 32'hBB);

    // Back-to-back reads starve the drain.
    wr(30'd8, 32'h1);
    wr(30'd9, 32'h2);
    for (int i = 0; i < 5; i++) begin
      rd(30'd0);
      check("r32_cnt", {30'd0, bus.WB_CNT}, 32'd1);
    end
    rd(30'd8);
    check("r32_rd8", bus.DRDATA, 32'h1);
    rd(30'd9);
    check("r32_rd9", bus.DRDATA, 32'h2);
    idle();

    rd(30'h400);
    check("r33_rd_err", {31'd0, bus.ERR}, 32'd1);
    check("r33_rd_data", bus.DRDATA, 32'd0);
    wr(30'h400, 32'hFF);
    check("r33_wr_err", {31'd0, bus.ERR}, 32'd1);
    check("r33_wr_cnt", {30'd0, bus.WB_CNT}, 32'd0);
    rd(30'd0);
    check("r33_err_clear", {31'd0, bus.ERR}, 32'd0);

    // Reset discards a pending write; the array keeps its old value.
    v4 = ref_mem[4];
    wr(30'd4, 32'h55);
    do_reset();
    rd(30'd4);
    check("r34_rd", bus.DRDATA, v4);
    check("r34_cnt", {30'd0, bus.WB_CNT}, 32'd0);

    for (int n = 0; n < 800; n++) begin
      op = $urandom_range(0, 99);
      ra = 30'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) ra[29:10] = 20'($urandom_range(1, 20'hFFFFF));
      if (op < 2) do_reset();
      else if (op < 25) idle();
      else if (op < 60) wr(ra, $urandom);
      else rd(ra);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter AW, default 10, word-address bits decoded by the internal data array.
REQ-002 Parameter ENTRY, default 1024, number of 32-bit words in the array (ENTRY = 2^AW).
REQ-003 CLK  input  1  single clock, all state updates on rising edge.
REQ-004 RSTN  input  1  reset, asynchronous, active-low.
REQ-005 DREQ  input  1  data access request from CPU data port, valid for one cycle per access.
REQ-006 DRW  input  1  access type: 1 = write, 0 = read; meaningful only when DREQ=1.
REQ-007 DADDR  input  30  word address.
REQ-008 DWDATA  input  32  write data, sampled when DREQ=1 and DRW=1.
REQ-009 DRDATA  output  32  read data, registered.
REQ-010 ERR  output  1  one-cycle pulse flagging an out-of-range access.
REQ-011 WB_CNT  output  2  current write-buffer occupancy (0..2).

Function
REQ-012 Array SHALL be single-ported: at most one array read or one array write per cycle.
REQ-013 Writes SHALL be posted into a 2-entry FIFO write buffer (address, data) and never stall the CPU.
REQ-014 Read with DREQ=1, DRW=0 in cycle N SHALL present data on DRDATA after the edge ending cycle N (1-cycle latency); DRDATA SHALL hold its value in cycles without a read.
REQ-015 Read data SHALL come from the newest buffer entry whose address matches DADDR[AW-1:0]; otherwise from the array.
REQ-016 Array port priority: CPU read first; else drain oldest buffer entry into array.
REQ-017 Cycle with DREQ=0, or DREQ=1 and DRW=1, and WB_CNT>0 SHALL drain exactly one entry (oldest first).
REQ-018 Write whose address matches an existing buffer entry SHALL overwrite that entry's data in place (merge); occupancy unchanged; FIFO order unchanged.
REQ-019 Non-merging write with WB_CNT=2 SHALL drain the oldest entry and enqueue the new one in the same cycle; the buffer SHALL never overflow.
REQ-020 Merging write coinciding with drain of the matched entry SHALL write the new data to the array directly and not re-enqueue.
REQ-021 Out-of-range: DREQ=1 with DADDR[29:AW] != 0 SHALL pulse ERR=1 for the next cycle; the write is dropped; a read returns DRDATA=0.
REQ-022 In-range accesses SHALL leave ERR=0 on the next cycle.
REQ-023 Back-to-back reads SHALL starve drain; buffer contents persist and remain forwarded until drained.
REQ-024 WB_CNT SHALL reflect occupancy after each edge: +1 enqueue, -1 drain, net 0 on simultaneous enqueue and drain.

Reset
REQ-025 RSTN low SHALL immediately force DRDATA=0, ERR=0, WB_CNT=0, buffer empty, regardless of CLK.
REQ-026 Pending buffered writes at reset assertion SHALL be discarded and not reach the array.
REQ-027 Array contents SHALL be unaffected by reset.
REQ-028 First access SHALL be accepted on the first rising edge after RSTN deasserts.

Verification
REQ-029 Write 0x12345678 to addr 5, then read addr 5 next cycle -> DRDATA=0x12345678 one cycle later (forwarded), WB_CNT=1 during read.
REQ-030 Writes A(addr 1)=0x11, B(addr 2)=0x22, C(addr 3)=0x33 on consecutive cycles -> WB_CNT 1,1,1 (drain each idle-port cycle); read addrs 1,2,3 afterwards return 0x11,0x22,0x33.
REQ-031 Write addr 7=0xAA, immediately write addr 7=0xBB, then 4 reads of addr 7 -> all return 0xBB; after 1 idle cycle array holds 0xBB, WB_CNT=0.
REQ-032 Two writes (addr 8=0x1, addr 9=0x2) followed by 5 reads of addr 0 -> WB_CNT stays at its post-write value, no drain; reads of addrs 8/9 return 0x1/0x2.
REQ-033 Read DADDR=0x400 (AW=10) -> ERR=1 one cycle, DRDATA=0; write DADDR=0x400 data 0xFF -> ERR=1, WB_CNT unchanged, later read of addr 0 unaffected.
REQ-034 Write addr 4=0x55, assert RSTN low before drain cycle, release, read addr 4 -> returns prior array value (not 0x55), WB_CNT=0, DRDATA=0 during reset.
